// File: rtl/nibble_alu_acc.sv
`default_nettype none
// ============================================================================
// Module      : nibble_alu_acc
// Description : Handshaked nibble ALU with add, subtract, accumulate-over-N
//               and clear. Supports wrap or saturate, carry/borrow and overflow
//               flags, a sticky protocol error flag and a valid/ready result
//               port with backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_alu_acc #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int ACC_LEN   = 4,
  parameter int SAT       = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 carry,
  output logic                 ovf,
  output logic                 err
);

  localparam int         CNT_W    = $clog2(ACC_LEN + 1);
  localparam logic [1:0] C_MD_ADD = 2'b00;
  localparam logic [1:0] C_MD_SUB = 2'b01;
  localparam logic [1:0] C_MD_ACC = 2'b10;
  localparam logic [1:0] C_MD_CLR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t               r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ovf_acc;
  logic [ACC_WIDTH-1:0] r_sum;
  logic                 r_carry;
  logic                 r_ovf;
  logic                 r_err;
  logic                 r_out_valid;

  logic                 w_accept;
  logic [WIDTH:0]       w_add;
  logic [WIDTH:0]       w_sub;
  logic                 w_borrow;
  logic [ACC_WIDTH-1:0] w_sub_res;
  logic [ACC_WIDTH:0]   w_acc_t;
  logic                 w_acc_ovf;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic                 w_ovf_next;
  logic [CNT_W-1:0]     w_cnt_next;
  logic                 w_last;

  // Beat acceptance: refused in HOLD and while reset is asserted
  assign in_ready = !reset && (r_state != ST_HOLD);
  assign w_accept = in_valid && in_ready;

  // Single-beat arithmetic; the borrow is the top bit of the extended difference
  assign w_add     = {1'b0, a} + {1'b0, b};
  assign w_sub     = {1'b0, a} - {1'b0, b};
  assign w_borrow  = w_sub[WIDTH];
  assign w_sub_res = (w_borrow && (SAT != 0)) ? '0 : ACC_WIDTH'(w_sub[WIDTH-1:0]);

  // Accumulator step: one spare bit detects overflow of the running sum
  assign w_acc_t    = {1'b0, r_acc} + (ACC_WIDTH+1)'(a) + (ACC_WIDTH+1)'(b);
  assign w_acc_ovf  = w_acc_t[ACC_WIDTH];
  assign w_acc_next = (w_acc_ovf && (SAT != 0)) ? '1 : w_acc_t[ACC_WIDTH-1:0];
  assign w_ovf_next = r_ovf_acc | w_acc_ovf;
  assign w_cnt_next = r_cnt + 1'b1;
  assign w_last     = (w_cnt_next == CNT_W'(ACC_LEN));

  // Control FSM with registered result, flags and handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf_acc   <= 1'b0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (mode)
              C_MD_ADD: begin
                r_sum       <= ACC_WIDTH'(w_add);
                r_carry     <= w_add[WIDTH];
                r_ovf       <= 1'b0;
                r_out_valid <= 1'b1;
                r_state     <= ST_HOLD;
              end
              C_MD_SUB: begin
                r_sum       <= w_sub_res;
                r_carry     <= w_borrow;
                r_ovf       <= 1'b0;
                r_out_valid <= 1'b1;
                r_state     <= ST_HOLD;
              end
              C_MD_ACC: begin
                if (ACC_LEN == 1) begin
                  // First beat is also the last; cannot overflow by width rule
                  r_sum       <= ACC_WIDTH'(w_add);
                  r_carry     <= 1'b0;
                  r_ovf       <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_acc       <= '0;
                  r_cnt       <= '0;
                  r_ovf_acc   <= 1'b0;
                  r_state     <= ST_HOLD;
                end else begin
                  r_acc     <= ACC_WIDTH'(w_add);
                  r_cnt     <= CNT_W'(1);
                  r_ovf_acc <= 1'b0;
                  r_state   <= ST_ACCUM;
                end
              end
              default: begin
                r_acc <= '0;
                r_cnt <= '0;
                r_err <= 1'b0;
              end
            endcase
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            case (mode)
              C_MD_ACC: begin
                if (w_last) begin
                  r_sum       <= w_acc_next;
                  r_ovf       <= w_ovf_next;
                  r_carry     <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_acc       <= '0;
                  r_cnt       <= '0;
                  r_ovf_acc   <= 1'b0;
                  r_state     <= ST_HOLD;
                end else begin
                  r_acc     <= w_acc_next;
                  r_cnt     <= w_cnt_next;
                  r_ovf_acc <= w_ovf_next;
                end
              end
              C_MD_CLR: begin
                r_acc     <= '0;
                r_cnt     <= '0;
                r_ovf_acc <= 1'b0;
                r_err     <= 1'b0;
                r_state   <= ST_IDLE;
              end
              // ADD/SUB mid-accumulation: beat dropped, protocol error latched
              default: r_err <= 1'b1;
            endcase
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign carry     = r_carry;
  assign ovf       = r_ovf;
  assign err       = r_err;

endmodule
`default_nettype wire
